commit_shadow_tracker: RTL and testbench

Retire-side tracker feeding the difftest commit stage. It accepts one retired instruction per cycle from the writeback stage, buffers retirements in a small FIFO, and maintains a 32-entry architectural shadow register file. For each retirement it emits a single-cycle commit pulse with PC, next PC and packed GPR state already reflecting that instruction, which the simulator-side comparison consumes. It also detects `ebreak` and, optionally, a commit-stall watchdog.

---
 rtl/commit_pkg.sv | 35 +++
 rtl/commit_fifo.sv | 83 ++++++++
 rtl/commit_shadow_tracker.sv | 182 ++++++++++++++++++
 tb/tb_commit_shadow_tracker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// ============================================================================
// Module : commit_pkg
// Brief  : Shared types and constants for the retire-side commit tracker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package commit_pkg;

    // Default datapath width. The retire entry layout is built from this
    // value, so a top-level XLEN override must be matched here.
    localparam int XLEN = 64;

    // Architectural integer register count.
    localparam int NUM_GPR = 32;

    // Tracker state: RUN accepts retirements, HALT only drains.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } trk_state_e;

    // One buffered retirement.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            wen;
        logic            ebreak;
    } retire_entry_t;

endpackage

`default_nettype wire

// File: rtl/commit_fifo.sv
// ============================================================================
// Module : commit_fifo
// Brief  : Synchronous circular FIFO of retire entries. Pushes while full and
//          pops while empty are ignored. No read-through bypass.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_fifo
    import commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  retire_entry_t              wr_entry,
    output retire_entry_t              rd_entry,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    retire_entry_t   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_entry = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

`default_nettype wire

// File: rtl/commit_shadow_tracker.sv
// ============================================================================
// Module : commit_shadow_tracker
// Brief  : Retire-side tracker for difftest. Buffers retirements, keeps a
//          32-entry shadow GPR file and emits one commit pulse per retired
//          instruction with GPR state already including that instruction.
//          Optional commit-stall watchdog enabled by `COMMIT_WATCHDOG_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_shadow_tracker
    import commit_pkg::*;
#(
    parameter int XLEN        = commit_pkg::XLEN,
    parameter int DEPTH       = 4,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   retire_valid,
    output logic                   retire_ready,
    input  logic [XLEN-1:0]        retire_pc,
    input  logic [XLEN-1:0]        retire_npc,
    input  logic [4:0]             retire_rd,
    input  logic [XLEN-1:0]        retire_wdata,
    input  logic                   retire_wen,
    input  logic                   retire_ebreak,
    input  logic                   sink_ready,
    output logic                   inst_commit,
    output logic [XLEN-1:0]        commit_pc,
    output logic [XLEN-1:0]        commit_npc,
    output logic [32*XLEN-1:0]     gpr_wire,
    output logic                   cpu_ebreak_sign,
    output logic [63:0]            commit_count,
    output logic                   halted,
    output logic                   hang
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_RUN  = RUN;
    localparam logic [0:0] ST_HALT = HALT;

    retire_entry_t   wr_entry;
    retire_entry_t   head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count_unused;
    logic            push;
    logic            pop;

    logic [0:0]      state_q, state_d;
    logic            inst_commit_q, inst_commit_d;
    logic            ebreak_sign_q, ebreak_sign_d;
    logic [XLEN-1:0] commit_pc_q, commit_pc_d;
    logic [XLEN-1:0] commit_npc_q, commit_npc_d;
    logic [63:0]     commit_count_q, commit_count_d;
    logic [XLEN-1:0] gpr_q [NUM_GPR];
    logic [XLEN-1:0] gpr_d [NUM_GPR];

    // Ready depends only on registered occupancy and state
    assign retire_ready = !fifo_full && (state_q == ST_RUN);
    assign push         = retire_valid && retire_ready;
    assign pop          = !fifo_empty && sink_ready;

    assign wr_entry = '{pc: retire_pc, npc: retire_npc, rd: retire_rd,
                        wdata: retire_wdata, wen: retire_wen,
                        ebreak: retire_ebreak};

    commit_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (fifo_count_unused),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Commit outputs, shadow GPR update and RUN/HALT transition on each pop
    always_comb begin
        state_d        = state_q;
        inst_commit_d  = pop;
        ebreak_sign_d  = pop && head.ebreak;
        commit_pc_d    = commit_pc_q;
        commit_npc_d   = commit_npc_q;
        commit_count_d = commit_count_q;
        gpr_d          = gpr_q;
        if (pop) begin
            commit_pc_d    = head.pc;
            commit_npc_d   = head.npc;
            commit_count_d = commit_count_q + 64'd1;
            if (head.wen && (head.rd != 5'd0)) begin
                gpr_d[head.rd] = head.wdata;
            end
            if (head.ebreak) begin
                state_d = ST_HALT;
            end
        end
        gpr_d[0] = '0;
    end

    // Commit-side registers; HALT is left only through reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            inst_commit_q  <= 1'b0;
            ebreak_sign_q  <= 1'b0;
            commit_pc_q    <= '0;
            commit_npc_q   <= '0;
            commit_count_q <= '0;
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            inst_commit_q  <= inst_commit_d;
            ebreak_sign_q  <= ebreak_sign_d;
            commit_pc_q    <= commit_pc_d;
            commit_npc_q   <= commit_npc_d;
            commit_count_q <= commit_count_d;
            gpr_q          <= gpr_d;
        end
    end

    // Pack shadow registers, x[i] in slice i
    for (genvar i = 0; i < NUM_GPR; i++) begin : g_pack
        assign gpr_wire[XLEN*i +: XLEN] = gpr_q[i];
    end

    assign inst_commit     = inst_commit_q;
    assign cpu_ebreak_sign = ebreak_sign_q;
    assign commit_pc       = commit_pc_q;
    assign commit_npc      = commit_npc_q;
    assign commit_count    = commit_count_q;
    assign halted          = (state_q == ST_HALT);

`ifdef COMMIT_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          hang_q, hang_d;

    // Count cycles since the last pop; idle while halted, saturate at the limit
    always_comb begin
        wdog_d = wdog_q;
        hang_d = hang_q;
        if (pop || (state_q == ST_HALT)) begin
            wdog_d = '0;
        end else if (wdog_q != WW'(WDOG_CYCLES)) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_d == WW'(WDOG_CYCLES)) begin
                hang_d = 1'b1;
            end
        end
    end

    // Watchdog registers; hang is sticky until reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
            hang_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            hang_q <= hang_d;
        end
    end

    assign hang = hang_q;
`else
    logic unused_wdog_cycles;
    assign unused_wdog_cycles = ^WDOG_CYCLES;
    assign hang = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_commit_shadow_tracker.sv
// ============================================================================
// Module : tb_commit_shadow_tracker
// Brief  : Directed self-checking bench for commit_shadow_tracker
//          (DEPTH=4, WDOG_CYCLES=16; watchdog steps with COMMIT_WATCHDOG_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_commit_shadow_tracker;

    localparam int XLEN = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              retire_valid;
    logic              retire_ready;
    logic [XLEN-1:0]   retire_pc;
    logic [XLEN-1:0]   retire_npc;
    logic [4:0]        retire_rd;
    logic [XLEN-1:0]   retire_wdata;
    logic              retire_wen;
    logic              retire_ebreak;
    logic              sink_ready;
    logic              inst_commit;
    logic [XLEN-1:0]   commit_pc;
    logic [XLEN-1:0]   commit_npc;
    logic [32*XLEN-1:0] gpr_wire;
    logic              cpu_ebreak_sign;
    logic [63:0]       commit_count;
    logic              halted;
    logic              hang;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    commit_shadow_tracker #(
        .XLEN            (XLEN),
        .DEPTH           (4),
        .WDOG_CYCLES     (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .retire_valid    (retire_valid),
        .retire_ready    (retire_ready),
        .retire_pc       (retire_pc),
        .retire_npc      (retire_npc),
        .retire_rd       (retire_rd),
        .retire_wdata    (retire_wdata),
        .retire_wen      (retire_wen),
        .retire_ebreak   (retire_ebreak),
        .sink_ready      (sink_ready),
        .inst_commit     (inst_commit),
        .commit_pc       (commit_pc),
        .commit_npc      (commit_npc),
        .gpr_wire        (gpr_wire),
        .cpu_ebreak_sign (cpu_ebreak_sign),
        .commit_count    (commit_count),
        .halted          (halted),
        .hang            (hang)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [4:0] rd,
                         input logic [63:0] wd, input logic wen, input logic eb);
        retire_valid  = v;
        retire_pc     = pc;
        retire_npc    = pc + 64'd4;
        retire_rd     = rd;
        retire_wdata  = wd;
        retire_wen    = wen;
        retire_ebreak = eb;
    endtask

    function automatic logic [63:0] gpr(input int i);
        return gpr_wire[64*i +: 64];
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset      = 1'b0;
        sink_ready = 1'b1;
        drive(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0);

        // ---- reset state ----
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_inst_commit", {63'b0, inst_commit}, 64'd0);
        chk("rst_commit_count", commit_count, 64'd0);
        chk("rst_commit_pc", commit_pc, 64'd0);
        chk("rst_gpr_any", {63'b0, |gpr_wire}, 64'd0);
        chk("rst_halted", {63'b0, halted}, 64'd0);
        chk("rst_hang", {63'b0, hang}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        chk("rst_ready", {63'b0, retire_ready}, 64'd1);

        // ---- single retire to x5 ----
        drive(1'b1, 64'h8000_0000, 5'd5, 64'h1234, 1'b1, 1'b0);
        @(posedge clock); #1;                 // push edge
        retire_valid = 1'b0;
        @(negedge clock);
        chk("single_no_early_pulse", {63'b0, inst_commit}, 64'd0);
        @(negedge clock);                     // after pop edge
        chk("single_pulse", {63'b0, inst_commit}, 64'd1);
        chk("single_pc", commit_pc, 64'h8000_0000);
        chk("single_npc", commit_npc, 64'h8000_0004);
        chk("single_x5", gpr_wire[383:320], 64'h1234);
        chk("single_count", commit_count, 64'd1);
        chk("single_ebreak_sign", {63'b0, cpu_ebreak_sign}, 64'd0);
        @(negedge clock);
        chk("single_pulse_end", {63'b0, inst_commit}, 64'd0);

        // ---- write to x0 is dropped but commits ----
        @(posedge clock); #1;
        drive(1'b1, 64'h8000_0004, 5'd0, 64'hFFFF, 1'b1, 1'b0);
        @(posedge clock); #1;
        retire_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("x0_pulse", {63'b0, inst_commit}, 64'd1);
        chk("x0_stays_zero", gpr(0), 64'd0);
        chk("x0_x5_kept", gpr(5), 64'h1234);
        chk("x0_count", commit_count, 64'd2);

        // ---- backpressure: fill 4 entries, 5th held off ----
        @(posedge clock); #1;
        sink_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h100 + 64'(4 * i), 5'(i + 1), 64'hA0 + 64'(i), 1'b1, 1'b0);
            @(posedge clock); #1;
        end
        chk("full_ready_low", {63'b0, retire_ready}, 64'd0);
        @(negedge clock);
        chk("full_no_pulse", {63'b0, inst_commit}, 64'd0);
        sink_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            if (k == 1) retire_valid = 1'b0;  // 5th entry taken on this edge
            @(negedge clock);
            chk("drain_pulse", {63'b0, inst_commit}, 64'd1);
            chk("drain_pc", commit_pc, 64'h100 + 64'(4 * k));
        end
        @(negedge clock);
        chk("drain_done", {63'b0, inst_commit}, 64'd0);
        chk("drain_count", commit_count, 64'd7);
        chk("drain_x1", gpr(1), 64'hA0);
        chk("drain_x4", gpr(4), 64'hA3);
        chk("drain_x5", gpr(5), 64'hA4);

        // ---- ebreak followed by two more retires ----
        @(posedge clock); #1;
        drive(1'b1, 64'h200, 5'd0, 64'h0, 1'b0, 1'b1);
        @(posedge clock); #1;                 // ebreak pushed
        drive(1'b1, 64'h204, 5'd6, 64'h66, 1'b1, 1'b0);
        @(posedge clock); #1;                 // ebreak pops, 0x204 pushed
        drive(1'b1, 64'h208, 5'd7, 64'h77, 1'b1, 1'b0);
        @(negedge clock);
        chk("ebk_pulse", {63'b0, inst_commit}, 64'd1);
        chk("ebk_sign", {63'b0, cpu_ebreak_sign}, 64'd1);
        chk("ebk_pc", commit_pc, 64'h200);
        chk("ebk_halted", {63'b0, halted}, 64'd1);
        chk("ebk_ready_low", {63'b0, retire_ready}, 64'd0);
        @(negedge clock);
        chk("ebk_drain_pulse", {63'b0, inst_commit}, 64'd1);
        chk("ebk_drain_pc", commit_pc, 64'h204);
        chk("ebk_drain_sign", {63'b0, cpu_ebreak_sign}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("halt_no_pulse", {63'b0, inst_commit}, 64'd0);
        end
        chk("halt_count", commit_count, 64'd9);
        chk("halt_x7_untouched", gpr(7), 64'd0);
        chk("halt_x6", gpr(6), 64'h66);
        chk("halt_hang", {63'b0, hang}, 64'd0);
        retire_valid = 1'b0;

        // ---- reset with 3 entries buffered ----
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        sink_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h300 + 64'(4 * i), 5'(10 + i), 64'h55 + 64'(i), 1'b1, 1'b0);
            @(posedge clock); #1;
        end
        retire_valid = 1'b0;
        reset        = 1'b0;
        sink_ready   = 1'b1;
        @(negedge clock);
        chk("mid_rst_no_pulse", {63'b0, inst_commit}, 64'd0);
        chk("mid_rst_count", commit_count, 64'd0);
        chk("mid_rst_gpr", {63'b0, |gpr_wire}, 64'd0);
        chk("mid_rst_halted", {63'b0, halted}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("post_rst_no_pulse", {63'b0, inst_commit}, 64'd0);
        end
        chk("post_rst_count", commit_count, 64'd0);
        chk("post_rst_ready", {63'b0, retire_ready}, 64'd1);

`ifdef COMMIT_WATCHDOG_EN
        // ---- watchdog: hang 16 edges after last pop ----
        @(posedge clock); #1;
        drive(1'b1, 64'h400, 5'd1, 64'h1, 1'b1, 1'b0);
        @(posedge clock); #1;
        retire_valid = 1'b0;
        @(posedge clock); #1;                 // pop edge
        chk("wdog_pulse", {63'b0, inst_commit}, 64'd1);
        repeat (15) @(posedge clock);
        @(negedge clock);
        chk("wdog_not_yet", {63'b0, hang}, 64'd0);
        @(negedge clock);
        chk("wdog_fired", {63'b0, hang}, 64'd1);
        repeat (5) @(negedge clock);
        chk("wdog_sticky", {63'b0, hang}, 64'd1);
`else
        repeat (40) @(negedge clock);
        chk("hang_tied_low", {63'b0, hang}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
